// File: rtl/moore_laser_fsm.sv
// Laser pulse timer: a sampled button press drives the laser enable high for
// exactly three clock cycles, then the machine returns to idle.
module moore_laser_fsm (
    input  logic clk,
    input  logic rst,
    input  logic b,
    output logic x
);

    typedef enum logic [1:0] {
        OFF = 2'b00,
        ON1 = 2'b01,
        ON2 = 2'b10,
        ON3 = 2'b11
    } state_t;

    // Name is fixed so benches can probe it hierarchically.
    state_t current_state;
    state_t next_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_state <= OFF;
        end else begin
            current_state <= next_state;
        end
    end

    // Once a pulse starts, the button is ignored until the machine is back in OFF.
    always_comb begin
        next_state = OFF;
        case (current_state)
            OFF:     next_state = b ? ON1 : OFF;
            ON1:     next_state = ON2;
            ON2:     next_state = ON3;
            ON3:     next_state = OFF;
            default: next_state = OFF;
        endcase
    end

    // The output depends on the state alone, so b can never glitch the laser.
    always_comb begin
        x = 1'b0;
        case (current_state)
            OFF:     x = 1'b0;
            ON1,
            ON2,
            ON3:     x = 1'b1;
            default: x = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_moore_laser_fsm.sv
// Scoreboard bench for moore_laser_fsm: stimulus queues the expected state after
// each clock edge; a monitor pops and checks it just after that edge.
module tb_moore_laser_fsm;

    logic clk;
    logic rst;
    logic b;
    logic x;

    typedef struct {
        logic [1:0] st;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    moore_laser_fsm uut (
        .clk (clk),
        .rst (rst),
        .b   (b),
        .x   (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [1:0] exp_st);
        logic [1:0] act_st;
        logic       exp_x;
        act_st = uut.current_state;
        exp_x  = (exp_st != 2'b00);
        n_cmp++;
        if (act_st !== exp_st) begin
            n_fail++;
            $display("FAIL %s state: got %b expected %b (t=%0t)", nm, act_st, exp_st, $time);
        end
        n_cmp++;
        if (x !== exp_x) begin
            n_fail++;
            $display("FAIL %s x: got %b expected %b (t=%0t)", nm, x, exp_x, $time);
        end
        $display("check %-14s state=%b x=%b exp_state=%b exp_x=%b", nm, act_st, x, exp_st, exp_x);
    endtask

    // Drive inputs at the falling edge; expected state is what follows the next rising edge.
    task automatic step(input logic rv, input logic bv, input logic [1:0] es, input string nm);
        exp_t e;
        @(negedge clk);
        rst = rv;
        b   = bv;
        e.st = es;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.nm, e.st);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        b   = 1'b0;

        // Asynchronous reset applied mid-cycle, before any clock edge.
        #2 rst = 1'b0;
        #1 check("rst_async", 2'b00);
        step(1'b0, 1'b0, 2'b00, "rst_hold0");
        step(1'b0, 1'b0, 2'b00, "rst_hold1");
        step(1'b1, 1'b0, 2'b00, "rst_release");
        step(1'b1, 1'b0, 2'b00, "idle");

        // Single one-cycle press.
        step(1'b1, 1'b1, 2'b01, "press_on1");
        step(1'b1, 1'b0, 2'b10, "press_on2");
        step(1'b1, 1'b0, 2'b11, "press_on3");
        step(1'b1, 1'b0, 2'b00, "press_off");
        step(1'b1, 1'b0, 2'b00, "press_stay");

        // Held button: 3 on, 1 off, repeat.
        step(1'b1, 1'b1, 2'b01, "held_on1");
        step(1'b1, 1'b1, 2'b10, "held_on2");
        step(1'b1, 1'b1, 2'b11, "held_on3");
        step(1'b1, 1'b1, 2'b00, "held_off");
        step(1'b1, 1'b1, 2'b01, "held_on1b");
        step(1'b1, 1'b0, 2'b10, "held_on2b");
        step(1'b1, 1'b0, 2'b11, "held_on3b");
        step(1'b1, 1'b0, 2'b00, "held_end");

        // Press while in ON2 is ignored.
        step(1'b1, 1'b1, 2'b01, "ign_on1");
        step(1'b1, 1'b0, 2'b10, "ign_on2");
        step(1'b1, 1'b1, 2'b11, "ign_on3");
        step(1'b1, 1'b0, 2'b00, "ign_off");
        step(1'b1, 1'b0, 2'b00, "ign_stay");

        // Reset mid-pulse aborts without a clock edge.
        step(1'b1, 1'b1, 2'b01, "mid_on1");
        step(1'b1, 1'b0, 2'b10, "mid_on2");
        @(posedge clk);
        #3;
        check("mid_pre_rst", 2'b10);
        rst = 1'b0;
        #1 check("mid_rst_async", 2'b00);
        step(1'b0, 1'b0, 2'b00, "mid_rst_hold");
        step(1'b1, 1'b0, 2'b00, "mid_release");
        step(1'b1, 1'b0, 2'b00, "mid_stay");

        // Reset released with button held enters ON1 on the first edge.
        step(1'b0, 1'b1, 2'b00, "rb_hold");
        step(1'b1, 1'b1, 2'b01, "rb_on1");
        step(1'b1, 1'b0, 2'b10, "rb_on2");
        step(1'b1, 1'b0, 2'b11, "rb_on3");
        step(1'b1, 1'b0, 2'b00, "rb_off");

        // Back-to-back: press raised during ON3 and held through OFF.
        step(1'b1, 1'b1, 2'b01, "b2b_on1");
        step(1'b1, 1'b0, 2'b10, "b2b_on2");
        step(1'b1, 1'b0, 2'b11, "b2b_on3");
        step(1'b1, 1'b1, 2'b00, "b2b_off");
        step(1'b1, 1'b1, 2'b01, "b2b_on1b");
        step(1'b1, 1'b0, 2'b10, "b2b_on2b");
        step(1'b1, 1'b0, 2'b11, "b2b_on3b");
        step(1'b1, 1'b0, 2'b00, "b2b_end");

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_laser_fsm.md
Name: moore_laser_fsm

Overview:
- Moore finite-state machine laser timer.
- A button press (b sampled high on a clock edge) fires the laser output x for exactly three clock cycles, then returns to idle.
- Stand-alone control block: one button input, one laser-enable output, internal state register exposed for debug by hierarchical reference.

Parameters:
- None. Pulse length is fixed at 3 cycles by the state set.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; rst=0 forces state OFF immediately, independent of clk
- b    input  1  button request; synchronous to clk, sampled on rising edge, no internal debounce or synchroniser
- x    output 1  laser enable; 1 = laser on

Behaviour:
- State register named current_state, 2 bits, binary encoding:
  - OFF=2'b00
  - ON1=2'b01
  - ON2=2'b10
  - ON3=2'b11
  - The register name is fixed so benches can probe uut.current_state.
- Structure:
  - Moore machine: x is a combinational decode of current_state only; b never reaches x combinationally.
  - Three blocks: async-reset state register, combinational next-state logic, combinational output decode.
  - Next-state logic assigns a default (OFF) for every path; no latches.
- Reset:
  - rst=0 forces current_state=OFF and x=0 asynchronously, and holds them while rst=0.
  - Release is observed on the next rising clk edge; the first transition can occur on that edge.
- Transitions (evaluated at each rising clk edge while rst=1):
  - OFF: b=1 -> ON1; b=0 -> stay OFF.
  - ON1 -> ON2 unconditionally (b ignored).
  - ON2 -> ON3 unconditionally.
  - ON3 -> OFF unconditionally, even if b=1.
- Output decode:
  - x=0 in OFF.
  - x=1 in ON1, ON2, ON3.
- Timing:
  - x rises one clk edge after b is sampled high.
  - x stays high for exactly 3 clock periods.
  - x falls on the 3rd edge after entry into ON1.
- Boundary conditions:
  - **Held button:** b=1 continuously gives repeating 3-on/1-off pulses (ON1, ON2, ON3, OFF, ON1, …). OFF always lasts at least one cycle between pulses.
  - **Button during a pulse:** presses while in ON1–ON3 are ignored and not queued; a press released before the machine returns to OFF is lost.
  - **Short press:** a 1-cycle b pulse coinciding with a rising edge in OFF is sufficient to trigger a full pulse.
  - **Reset mid-pulse:** rst asserted in ON1/ON2/ON3 aborts the pulse; x=0 immediately.
  - **Reset with button held:** rst deasserted while b=1 enters ON1 on the first rising edge after release.
  - **Unknown input:** X on b in OFF is not specified. Benches must drive b to 0 or 1.

Test Plan:
- Reset: rst=0 for 2 cycles with b=0, applied asynchronously mid-cycle -> current_state=00 and x=0 immediately, before any clk edge; remain so after rst=1 with b=0.
- Single press:
  - Stimulus: b=1 for one 10 ns cycle, then 0.
  - Required: x=1 starting at the first edge after b is sampled; state 01, 10, 11 on consecutive edges; x=0 and state 00 on the 3rd edge after entry; stays 00.
- Held button: b=1 for 5 cycles -> state sequence 01, 10, 11, 00, 01; x high 3 cycles, low 1 cycle, high again.
- Press ignored while active: b pulses 1 while in ON2 only -> no extension; pulse still exactly 3 cycles; then OFF.
- Reset mid-pulse: rst=0 asserted while in ON2 -> state 00 and x=0 without a clock edge; after release with b=0, stays OFF.
- Back-to-back: b re-asserted exactly in the cycle the state is ON3 and held through the OFF cycle -> one OFF cycle (x=0), then a new 3-cycle pulse.
